// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data BRAM. Grants at most one access per cycle
// and tags read returns to the requester that issued them.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned CPU_PRIO   = 0,
    parameter int unsigned STARVE_LIM = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    req_id_e           rr_last_q, rr_last_d;
    logic [7:0]        starve_q, starve_d;
    logic [RD_LAT-1:0] rv_q, rv_d;
    logic [RD_LAT-1:0] rid_q, rid_d;
    logic              win1;

    // win1 says who takes a contended cycle; rst gates grants so nothing issues in reset.
    always_comb begin
        win1 = 1'b0;
        if (CPU_PRIO == 0) begin
            win1 = (rr_last_q == REQ0);
        end else begin
            win1 = (starve_q == 8'(STARVE_LIM));
        end
        m0_gnt = rst && m0_req && !(m1_req && win1);
        m1_gnt = rst && m1_req && !(m0_req && !win1);
    end

    always_comb begin
        mem_wea   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_wea   = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_wea   = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (m0_gnt) begin
            rr_last_d = REQ0;
        end else if (m1_gnt) begin
            rr_last_d = REQ1;
        end

        starve_d = starve_q;
        if (!m1_req || m1_gnt) begin
            starve_d = '0;
        end else if (starve_q < 8'(STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end

        rv_d     = '0;
        rid_d    = '0;
        rv_d[0]  = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
        rid_d[0] = m1_gnt;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rv_d[i]  = rv_q[i-1];
            rid_d[i] = rid_q[i-1];
        end
    end

    // Reset leaves the pointer on REQ1 so requester 0 takes the first contended cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= REQ1;
            starve_q  <= '0;
            rv_q      <= '0;
            rid_q     <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            starve_q  <= starve_d;
            rv_q      <= rv_d;
            rid_q     <= rid_d;
        end
    end

    assign m0_rvalid = rv_q[RD_LAT-1] && !rid_q[RD_LAT-1];
    assign m1_rvalid = rv_q[RD_LAT-1] &&  rid_q[RD_LAT-1];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin, CPU-priority and RD_LAT=2 instances share
// one stimulus set; a write-first BRAM model feeds mem_rdata from the round-robin instance.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [9:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] mem_rdata;

    logic        r_g0, r_g1, r_v0, r_v1, r_wea;
    logic [31:0] r_d0, r_d1, r_wd;
    logic [9:0]  r_a;
    logic        p_g0, p_g1, p_v0, p_v1, p_wea;
    logic [31:0] p_d0, p_d1, p_wd;
    logic [9:0]  p_a;
    logic        l_g0, l_g1, l_v0, l_v1, l_wea;
    logic [31:0] l_d0, l_d1, l_wd;
    logic [9:0]  l_a;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1), .CPU_PRIO(0), .STARVE_LIM(15)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(r_g0), .m0_rvalid(r_v0), .m0_rdata(r_d0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(r_g1), .m1_rvalid(r_v1), .m1_rdata(r_d1),
        .mem_wea(r_wea), .mem_addr(r_a), .mem_wdata(r_wd), .mem_rdata(mem_rdata));

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1), .CPU_PRIO(1), .STARVE_LIM(3)) u_prio (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(p_g0), .m0_rvalid(p_v0), .m0_rdata(p_d0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(p_g1), .m1_rvalid(p_v1), .m1_rdata(p_d1),
        .mem_wea(p_wea), .mem_addr(p_a), .mem_wdata(p_wd), .mem_rdata(mem_rdata));

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2), .CPU_PRIO(0), .STARVE_LIM(15)) u_lat2 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(l_g0), .m0_rvalid(l_v0), .m0_rdata(l_d0),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(l_g1), .m1_rvalid(l_v1), .m1_rdata(l_d1),
        .mem_wea(l_wea), .mem_addr(l_a), .mem_wdata(l_wd), .mem_rdata(mem_rdata));

    // Write-first BRAM model, preloaded with 0xA5A50000 | addr.
    logic [31:0] bram [1024];
    logic [31:0] bram_q = '0;
    initial for (int i = 0; i < 1024; i++) bram[i] = 32'hA5A50000 | 32'(i);
    always @(posedge clk) begin
        if (r_wea) begin
            bram[r_a] <= r_wd;
            bram_q    <= r_wd;
        end else begin
            bram_q <= bram[r_a];
        end
    end
    assign mem_rdata = bram_q;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h155; m0_wdata = 32'h12345678;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h2AA; m1_wdata = 32'h87654321;
        @(negedge clk);
        checks++; if ({r_g0, r_g1, p_g0, p_g1} !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b required 0000", {r_g0, r_g1, p_g0, p_g1}); end
        checks++; if (r_wea !== 1'b0) begin errors++; $display("FAIL reset_wea: got %b required 0", r_wea); end
        checks++; if (r_a !== 10'h0) begin errors++; $display("FAIL reset_addr: got %h required 000", r_a); end
        checks++; if (r_wd !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", r_wd); end
        checks++; if ({r_v0, r_v1, l_v0, l_v1} !== 4'b0) begin errors++; $display("FAIL reset_rvalid: got %b required 0000", {r_v0, r_v1, l_v0, l_v1}); end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'h004;
        @(negedge clk);
        checks++; if ({r_g0, r_g1} !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b required 10", {r_g0, r_g1}); end
        checks++; if (r_a !== 10'h004) begin errors++; $display("FAIL single_addr: got %h required 004", r_a); end
        checks++; if (r_wea !== 1'b0) begin errors++; $display("FAIL single_wea: got %b required 0", r_wea); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if ({r_v0, r_v1} !== 2'b10) begin errors++; $display("FAIL single_rvalid: got %b required 10", {r_v0, r_v1}); end
        checks++; if (r_d0 !== 32'hA5A50004) begin errors++; $display("FAIL single_rdata: got %h required a5a50004", r_d0); end
        next_cycle();
    endtask

    task automatic test_rr_contention();
        logic pg0, pg1;
        apply_reset();
        m0_req = 1'b1; m0_addr = 10'h010;
        m1_req = 1'b1; m1_addr = 10'h020;
        pg0 = 1'b0; pg1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle_inputs();
            @(negedge clk);
            if (k < 4) begin
                checks++; if ({r_g0, r_g1} !== {k[0] == 1'b0, k[0] == 1'b1}) begin errors++; $display("FAIL rr_gnt[%0d]: got %b required %b", k, {r_g0, r_g1}, {k[0] == 1'b0, k[0] == 1'b1}); end
                checks++; if (r_a !== (k[0] ? 10'h020 : 10'h010)) begin errors++; $display("FAIL rr_addr[%0d]: got %h required %h", k, r_a, (k[0] ? 10'h020 : 10'h010)); end
            end
            if (k > 0) begin
                checks++; if ({r_v0, r_v1} !== {pg0, pg1}) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b required %b", k, {r_v0, r_v1}, {pg0, pg1}); end
                checks++; if (r_d1 !== (pg0 ? 32'hA5A50010 : 32'hA5A50020)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h required %h", k, r_d1, (pg0 ? 32'hA5A50010 : 32'hA5A50020)); end
            end
            pg0 = (k < 4) && (k[0] == 1'b0);
            pg1 = (k < 4) && (k[0] == 1'b1);
            next_cycle();
        end
    endtask

    task automatic test_write_then_read();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h3FF; m1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({r_g0, r_g1, r_wea} !== 3'b011) begin errors++; $display("FAIL wr_gnt_wea: got %b required 011", {r_g0, r_g1, r_wea}); end
        checks++; if ({r_a, r_wd} !== {10'h3FF, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_bus: got %h/%h required 3ff/deadbeef", r_a, r_wd); end
        next_cycle();
        idle_inputs();
        m0_req = 1'b1; m0_addr = 10'h3FF;
        @(negedge clk);
        checks++; if ({r_g0, r_wea, r_v0, r_v1} !== 4'b1000) begin errors++; $display("FAIL rd_after_wr: got %b required 1000", {r_g0, r_wea, r_v0, r_v1}); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if ({r_v0, r_v1, r_wea} !== 3'b100) begin errors++; $display("FAIL wr_rvalid: got %b required 100", {r_v0, r_v1, r_wea}); end
        checks++; if (r_d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata: got %h required deadbeef", r_d0); end
        next_cycle();
    endtask

    task automatic test_cpu_prio();
        apply_reset();
        m0_req = 1'b1; m0_addr = 10'h011;
        m1_req = 1'b1; m1_addr = 10'h022;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if ({p_g0, p_g1} !== {(k % 4) != 3, (k % 4) == 3}) begin errors++; $display("FAIL prio_gnt[%0d]: got %b required %b", k, {p_g0, p_g1}, {(k % 4) != 3, (k % 4) == 3}); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        m0_req = 1'b1; m0_addr = 10'h030;
        @(negedge clk);
        checks++; if (l_g0 !== 1'b1) begin errors++; $display("FAIL lat2_gnt: got %b required 1", l_g0); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (l_v0 !== 1'b0) begin errors++; $display("FAIL lat2_early: got %b required 0", l_v0); end
        next_cycle();
        @(negedge clk);
        checks++; if ({l_v0, l_v1} !== 2'b10) begin errors++; $display("FAIL lat2_rvalid: got %b required 10", {l_v0, l_v1}); end
        next_cycle();
        m0_req = 1'b1; m0_addr = 10'h031;
        @(negedge clk);
        checks++; if (l_g0 !== 1'b1) begin errors++; $display("FAIL mid_gnt: got %b required 1", l_g0); end
        next_cycle();
        rst = 1'b0;
        m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
        @(negedge clk);
        checks++; if ({l_g0, l_g1, l_wea} !== 3'b000) begin errors++; $display("FAIL mid_rst_bus: got %b required 000", {l_g0, l_g1, l_wea}); end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({l_v0, l_v1} !== 2'b00) begin errors++; $display("FAIL mid_rvalid[%0d]: got %b required 00", k, {l_v0, l_v1}); end
            next_cycle();
        end
    endtask

    task automatic test_withdraw();
        apply_reset();
        m0_req = 1'b1; m0_addr = 10'h010;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'h055; m1_wdata = 32'h0BADF00D;
        @(negedge clk);
        checks++; if ({p_g0, p_g1, p_wea} !== 3'b100) begin errors++; $display("FAIL wd_lose: got %b required 100", {p_g0, p_g1, p_wea}); end
        checks++; if (p_a !== 10'h010) begin errors++; $display("FAIL wd_addr: got %h required 010", p_a); end
        next_cycle();
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        checks++; if ({p_g0, p_g1, p_wea} !== 3'b100) begin errors++; $display("FAIL wd_drop: got %b required 100", {p_g0, p_g1, p_wea}); end
        next_cycle();
        // A stale count of 1 would let m1 win on the 3rd contended cycle instead of the 4th.
        m1_req = 1'b1; m1_addr = 10'h056;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if ({p_g0, p_g1} !== {k != 3, k == 3}) begin errors++; $display("FAIL wd_starve[%0d]: got %b required %b", k, {p_g0, p_g1}, {k != 3, k == 3}); end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_contention();
        test_write_then_read();
        test_cpu_prio();
        test_reset_midflight();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data BRAM (1-cycle read latency, 10-bit word address, 32-bit data, single write enable).
- Requester 0 is the RISC-V CPU data port; requester 1 is the CGRA/loader port.
- Sits between both masters and the data RAM.
- Per cycle it grants at most one access, drives the BRAM, and returns read data tagged to the correct requester.
- Includes anti-starvation for requester 1 when CPU priority is enabled.

Parameters:
- ADDR_W, 10, word address width (matches BRAM addra).
- DATA_W, 32, data width.
- RD_LAT, 1, BRAM read latency in cycles (legal values 1..3).
- CPU_PRIO, 0, 0 = round-robin; 1 = requester 0 wins contention, subject to the starvation limit.
- STARVE_LIM, 15, in CPU_PRIO=1 mode, consecutive denied cycles of requester 1 before it is forced to win (range 1..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  requester 0 access request.
- m0_we  input  1  requester 0 write (1) / read (0).
- m0_addr  input  ADDR_W  requester 0 word address.
- m0_wdata  input  DATA_W  requester 0 write data.
- m0_gnt  output  1  requester 0 access accepted this cycle.
- m0_rvalid  output  1  requester 0 read data valid this cycle.
- m0_rdata  output  DATA_W  requester 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: as above, for requester 1.
- mem_wea  output  1  BRAM write enable.
- mem_addr  output  ADDR_W  BRAM address.
- mem_wdata  output  DATA_W  BRAM write data.
- mem_rdata  input  DATA_W  BRAM read data.

Behaviour:
- Reset (rst=0, async):
  - gnt, rvalid, mem_wea all 0; mem_addr 0; mem_wdata 0.
  - Read-tag pipeline cleared.
  - RR pointer set so requester 0 wins the first contention.
  - Starvation counter 0.
- Grant is combinational from the current reqs and registered arbitration state. At most one gnt is high per cycle, and gnt=0 while rst=0.
- Request holding: a requester holds req/we/addr/wdata stable until it sees gnt high. The access is accepted on the rising edge ending the gnt cycle. A new request may follow in the next cycle.
- Single request: granted in the same cycle (zero arbitration latency).
- Contention, CPU_PRIO=0: grant goes to the requester not granted most recently. The pointer updates on every grant, including uncontended ones.
- Contention, CPU_PRIO=1: requester 0 wins, unless the starvation counter equals STARVE_LIM; then requester 1 wins.
  - The counter increments on each cycle where m1_req=1 and m1_gnt=0, saturating at STARVE_LIM.
  - It clears on m1_gnt. It also clears whenever m1_req=0.
- Memory drive (combinational mux):
  - Granted requester's addr/wdata go to mem_addr/mem_wdata; mem_wea = granted we.
  - No grant: mem_wea=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read pushes {valid, id} into an RD_LAT-deep shift register.
  - mX_rvalid is high exactly RD_LAT cycles after the gnt cycle, for one cycle, for the owning id only.
  - Writes push valid=0 and produce no rvalid.
- m0_rdata and m1_rdata both equal mem_rdata at all times; they are meaningful only with rvalid.
- Back-to-back: one access per cycle sustained. Throughput is 1 access/cycle total under contention, and each requester gets at least 1 per 2 cycles in RR mode.
- Same-address write then read in consecutive cycles: the read returns the newly written data (BRAM write-first ordering is passed through untouched).
- Reset mid-operation: in-flight reads are dropped with no rvalid after reset; arbitration state returns to reset values.
- A requester dropping req before gnt is tolerated: the request is withdrawn and nothing is issued.

Test Plan:
- Reset then m0 read only, addr 0x004, RD_LAT=1 -> m0_gnt high in the same cycle; mem_addr=0x004, mem_wea=0; next cycle m0_rvalid=1, m0_rdata=mem_rdata, m1_rvalid=0.
- RR mode, both reqs reading for 4 cycles (m0 addr 0x010, m1 addr 0x020) -> grants alternate m0, m1, m0, m1; rvalid follows the same order 1 cycle later; no cycle has two gnts.
- m1 writes 0xDEADBEEF to 0x3FF, next cycle m0 reads 0x3FF -> mem_wea=1 only in the write cycle; m0_rdata=0xDEADBEEF with m0_rvalid; no rvalid for the write.
- CPU_PRIO=1, STARVE_LIM=3, m0_req and m1_req held high -> m0 granted for 3 cycles, m1 granted on the 4th, counter clears, pattern repeats.
- m0 read granted, rst asserted in the next cycle before rvalid (RD_LAT=2) -> no rvalid after rst releases; gnt=0 and mem_wea=0 while rst=0.
- m1_req pulses for one cycle while losing contention, then drops -> no m1_gnt, no BRAM access for m1, starvation counter back to 0.
